// File: rtl/l1_l2_arbiter_n.sv
// -----------------------------------------------------------------------------
// l1_l2_arbiter_n
// Arbitrates N private L1 channels onto the single shared L2 request port,
// one outstanding transaction at a time, and sequences the hierarchy flush.
//
// Ports
//   clk, reset_n           clock, synchronous active-low reset
//   req_*                  per-channel request strobe / address / data / opcode
//   req_ack, rsp_valid     per-channel accept and response strobes
//   rsp_load_data          L2 load data, shared by all channels
//   l2_req_*, l2_rsp_*     shared L2 request / response port
//   l1_flush_req/complete  per-channel L1 flush start / done strobes
//   l2_flush_req/complete  L2 flush start pulse / done strobe
//   in_flush_mode          flush sequence active
//   flush_done             one-cycle pulse at the end of a flush sequence
//   gnt_idx                channel currently or most recently granted
// -----------------------------------------------------------------------------
module l1_l2_arbiter_n #(
   parameter int N_REQ   = 2,
   parameter int ADDR_W  = 32,
   parameter int LINE_W  = 128,
   parameter int OP_W    = 4,
   parameter int RR_MODE = 1
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ*ADDR_W-1:0]    req_addr,
   input  logic [N_REQ*LINE_W-1:0]    req_store_data,
   input  logic [N_REQ*OP_W-1:0]      req_opcode,
   output logic [N_REQ-1:0]           req_ack,
   output logic [N_REQ-1:0]           rsp_valid,
   output logic [LINE_W-1:0]          rsp_load_data,
   output logic                       l2_req_valid,
   input  logic                       l2_req_ack,
   output logic [ADDR_W-1:0]          l2_req_addr,
   output logic [LINE_W-1:0]          l2_req_store_data,
   output logic [OP_W-1:0]            l2_req_opcode,
   input  logic                       l2_rsp_valid,
   input  logic [LINE_W-1:0]          l2_rsp_load_data,
   input  logic [N_REQ-1:0]           l1_flush_req,
   input  logic [N_REQ-1:0]           l1_flush_complete,
   output logic                       l2_flush_req,
   input  logic                       l2_flush_complete,
   output logic                       in_flush_mode,
   output logic                       flush_done,
   output logic [$clog2(N_REQ)-1:0]   gnt_idx
);

   localparam int GW = $clog2(N_REQ);

   typedef enum logic [1:0] {
      ARB_IDLE     = 2'd0,
      ARB_GRANT    = 2'd1,
      ARB_WAIT_RSP = 2'd2
   } arb_state_e;

   typedef enum logic [1:0] {
      F_IDLE    = 2'd0,
      F_WAIT_L1 = 2'd1,
      F_L2      = 2'd2
   } flush_state_e;

   arb_state_e          arb_q, arb_d;
   flush_state_e        f_q, f_d;
   logic [N_REQ-1:0]    pend_q, pend_d;
   logic [N_REQ-1:0]    need_q, need_d;
   logic [N_REQ-1:0]    done_q, done_d;
   logic [GW-1:0]       last_gnt_q, last_gnt_d;
   logic [GW-1:0]       gnt_q, gnt_d;
   logic                l2_req_valid_q, l2_req_valid_d;
   logic                l2_flush_req_q, l2_flush_req_d;
   logic                in_flush_q, in_flush_d;
   logic                flush_done_q, flush_done_d;

   logic [N_REQ-1:0]    cand_s;
   logic [N_REQ-1:0]    gnt_oh_s;
   logic [GW-1:0]       cand_idx_s;
   logic [GW-1:0]       win_idx_s;
   logic                win_found_s;
   logic                hit_s;
   logic                grant_s;

   // Winner search: round-robin starts just after the last grant, fixed
   // priority starts at channel 0; the first candidate found wins.
   always_comb begin
      cand_s      = pend_q | req_valid;
      win_found_s = 1'b0;
      win_idx_s   = {GW{1'b0}};
      cand_idx_s  = {GW{1'b0}};
      hit_s       = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand_idx_s  = (RR_MODE != 0) ? GW'((int'(last_gnt_q) + k) % N_REQ)
                                      : GW'(k - 1);
         hit_s       = !win_found_s && cand_s[cand_idx_s];
         win_idx_s   = hit_s ? cand_idx_s : win_idx_s;
         win_found_s = win_found_s | hit_s;
      end
   end

   // Arbiter next state, pending bookkeeping and grant tracking.
   always_comb begin
      arb_d   = arb_q;
      grant_s = (arb_q == ARB_IDLE) && win_found_s && (f_q != F_L2);
      case (arb_q)
         ARB_IDLE: begin
            if (grant_s) arb_d = ARB_GRANT;
            else         arb_d = ARB_IDLE;
         end
         ARB_GRANT: begin
            // A response during GRANT doubles as the ack.
            if (l2_rsp_valid)     arb_d = ARB_IDLE;
            else if (l2_req_ack)  arb_d = ARB_WAIT_RSP;
            else                  arb_d = ARB_GRANT;
         end
         ARB_WAIT_RSP: begin
            if (l2_rsp_valid) arb_d = ARB_IDLE;
            else              arb_d = ARB_WAIT_RSP;
         end
         default: arb_d = ARB_IDLE;
      endcase
      gnt_oh_s       = grant_s ? ({{(N_REQ-1){1'b0}}, 1'b1} << win_idx_s)
                               : {N_REQ{1'b0}};
      // A re-request during the channel's own grant survives: only the
      // winning cycle clears its pending bit.
      pend_d         = (pend_q | req_valid) & ~gnt_oh_s;
      last_gnt_d     = grant_s ? win_idx_s : last_gnt_q;
      gnt_d          = grant_s ? win_idx_s : gnt_q;
      l2_req_valid_d = (arb_d == ARB_GRANT);
   end

   // Flush sequencer. The L2 flush starts only once every requesting L1 is
   // done and the arbiter will be idle next cycle, so no transaction overlaps it.
   always_comb begin
      f_d            = f_q;
      need_d         = need_q;
      done_d         = done_q;
      l2_flush_req_d = 1'b0;
      flush_done_d   = 1'b0;
      case (f_q)
         F_IDLE: begin
            if (|l1_flush_req) begin
               f_d    = F_WAIT_L1;
               need_d = l1_flush_req;
               done_d = l1_flush_req & l1_flush_complete;
            end else begin
               f_d    = F_IDLE;
               need_d = {N_REQ{1'b0}};
               done_d = {N_REQ{1'b0}};
            end
         end
         F_WAIT_L1: begin
            need_d = need_q | l1_flush_req;
            done_d = done_q | l1_flush_complete;
            if (((need_d & ~done_d) == {N_REQ{1'b0}}) && (arb_d == ARB_IDLE)) begin
               f_d            = F_L2;
               l2_flush_req_d = 1'b1;
            end else begin
               f_d            = F_WAIT_L1;
            end
         end
         F_L2: begin
            if (l2_flush_complete) begin
               f_d          = F_IDLE;
               need_d       = {N_REQ{1'b0}};
               done_d       = {N_REQ{1'b0}};
               flush_done_d = 1'b1;
            end else begin
               f_d          = F_L2;
            end
         end
         default: begin
            f_d    = F_IDLE;
            need_d = {N_REQ{1'b0}};
            done_d = {N_REQ{1'b0}};
         end
      endcase
      in_flush_d = (f_d != F_IDLE);
   end

   // All state and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         arb_q          <= ARB_IDLE;
         f_q            <= F_IDLE;
         pend_q         <= {N_REQ{1'b0}};
         need_q         <= {N_REQ{1'b0}};
         done_q         <= {N_REQ{1'b0}};
         last_gnt_q     <= GW'(N_REQ - 1);
         gnt_q          <= {GW{1'b0}};
         l2_req_valid_q <= 1'b0;
         l2_flush_req_q <= 1'b0;
         in_flush_q     <= 1'b0;
         flush_done_q   <= 1'b0;
      end else begin
         arb_q          <= arb_d;
         f_q            <= f_d;
         pend_q         <= pend_d;
         need_q         <= need_d;
         done_q         <= done_d;
         last_gnt_q     <= last_gnt_d;
         gnt_q          <= gnt_d;
         l2_req_valid_q <= l2_req_valid_d;
         l2_flush_req_q <= l2_flush_req_d;
         in_flush_q     <= in_flush_d;
         flush_done_q   <= flush_done_d;
      end
   end

   // Ack and response steering to the granted channel only.
   always_comb begin
      req_ack   = {N_REQ{1'b0}};
      rsp_valid = {N_REQ{1'b0}};
      if (arb_q == ARB_GRANT) begin
         req_ack[gnt_q]   = l2_req_ack;
         rsp_valid[gnt_q] = l2_rsp_valid;
      end else if (arb_q == ARB_WAIT_RSP) begin
         rsp_valid[gnt_q] = l2_rsp_valid;
      end else begin
         req_ack   = {N_REQ{1'b0}};
         rsp_valid = {N_REQ{1'b0}};
      end
   end

   // Request fields come live from the granted channel; it holds them stable.
   assign l2_req_addr       = req_addr[gnt_q*ADDR_W +: ADDR_W];
   assign l2_req_store_data = req_store_data[gnt_q*LINE_W +: LINE_W];
   assign l2_req_opcode     = req_opcode[gnt_q*OP_W +: OP_W];
   assign rsp_load_data     = l2_rsp_load_data;

   assign l2_req_valid  = l2_req_valid_q;
   assign l2_flush_req  = l2_flush_req_q;
   assign in_flush_mode = in_flush_q;
   assign flush_done    = flush_done_q;
   assign gnt_idx       = gnt_q;

endmodule

// File: tb/tb_l1_l2_arbiter_n.sv
// -----------------------------------------------------------------------------
// tb_l1_l2_arbiter_n
// Directed bench for l1_l2_arbiter_n. Two 4-channel instances share stimulus:
// u_rr (round-robin) and u_fp (fixed priority). Inputs change 1 time unit after
// the rising edge; outputs are compared on the falling edge or at that point.
// -----------------------------------------------------------------------------
module tb_l1_l2_arbiter_n;

   localparam int N = 4;
   localparam int A = 32;
   localparam int L = 128;
   localparam int O = 4;

   logic           clk = 1'b0;
   logic           reset_n;
   logic [N-1:0]   req_valid;
   logic [N*A-1:0] req_addr;
   logic [N*L-1:0] req_store_data;
   logic [N*O-1:0] req_opcode;
   logic           l2_req_ack;
   logic           l2_rsp_valid;
   logic [L-1:0]   l2_rsp_load_data;
   logic [N-1:0]   l1_flush_req;
   logic [N-1:0]   l1_flush_complete;
   logic           l2_flush_complete;

   logic [N-1:0] rr_req_ack, rr_rsp_valid, fp_req_ack, fp_rsp_valid;
   logic [L-1:0] rr_rsp_load_data, fp_rsp_load_data;
   logic         rr_l2_req_valid, fp_l2_req_valid;
   logic [A-1:0] rr_l2_req_addr, fp_l2_req_addr;
   logic [L-1:0] rr_l2_req_store_data, fp_l2_req_store_data;
   logic [O-1:0] rr_l2_req_opcode, fp_l2_req_opcode;
   logic         rr_l2_flush_req, fp_l2_flush_req;
   logic         rr_in_flush_mode, fp_in_flush_mode;
   logic         rr_flush_done, fp_flush_done;
   logic [1:0]   rr_gnt_idx, fp_gnt_idx;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   l1_l2_arbiter_n #(.N_REQ(N), .ADDR_W(A), .LINE_W(L), .OP_W(O), .RR_MODE(1)) u_rr (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
      .req_store_data(req_store_data), .req_opcode(req_opcode),
      .req_ack(rr_req_ack), .rsp_valid(rr_rsp_valid), .rsp_load_data(rr_rsp_load_data),
      .l2_req_valid(rr_l2_req_valid), .l2_req_ack(l2_req_ack), .l2_req_addr(rr_l2_req_addr),
      .l2_req_store_data(rr_l2_req_store_data), .l2_req_opcode(rr_l2_req_opcode),
      .l2_rsp_valid(l2_rsp_valid), .l2_rsp_load_data(l2_rsp_load_data),
      .l1_flush_req(l1_flush_req), .l1_flush_complete(l1_flush_complete),
      .l2_flush_req(rr_l2_flush_req), .l2_flush_complete(l2_flush_complete),
      .in_flush_mode(rr_in_flush_mode), .flush_done(rr_flush_done), .gnt_idx(rr_gnt_idx)
   );

   l1_l2_arbiter_n #(.N_REQ(N), .ADDR_W(A), .LINE_W(L), .OP_W(O), .RR_MODE(0)) u_fp (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
      .req_store_data(req_store_data), .req_opcode(req_opcode),
      .req_ack(fp_req_ack), .rsp_valid(fp_rsp_valid), .rsp_load_data(fp_rsp_load_data),
      .l2_req_valid(fp_l2_req_valid), .l2_req_ack(l2_req_ack), .l2_req_addr(fp_l2_req_addr),
      .l2_req_store_data(fp_l2_req_store_data), .l2_req_opcode(fp_l2_req_opcode),
      .l2_rsp_valid(l2_rsp_valid), .l2_rsp_load_data(l2_rsp_load_data),
      .l1_flush_req(l1_flush_req), .l1_flush_complete(l1_flush_complete),
      .l2_flush_req(fp_l2_flush_req), .l2_flush_complete(l2_flush_complete),
      .in_flush_mode(fp_in_flush_mode), .flush_done(fp_flush_done), .gnt_idx(fp_gnt_idx)
   );

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_strobes();
      req_valid         = 4'b0000;
      l2_req_ack        = 1'b0;
      l2_rsp_valid      = 1'b0;
      l2_rsp_load_data  = 128'h0;
      l1_flush_req      = 4'b0000;
      l1_flush_complete = 4'b0000;
      l2_flush_complete = 1'b0;
   endtask

   task automatic apply_reset();
      clear_strobes();
      reset_n = 1'b0;
      nxt();
      nxt();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      clear_strobes();
      reset_n   = 1'b0;
      req_valid = 4'b1111;
      nxt();
      nxt();
      @(negedge clk);
      checks++;
      if ({rr_l2_req_valid, rr_req_ack, rr_rsp_valid, rr_l2_flush_req, rr_in_flush_mode,
           rr_flush_done, rr_gnt_idx} !== 14'd0) begin
         errors++;
         $display("FAIL reset_outputs_rr: got %b expected all zero", {rr_l2_req_valid, rr_req_ack,
                  rr_rsp_valid, rr_l2_flush_req, rr_in_flush_mode, rr_flush_done, rr_gnt_idx});
      end
      checks++;
      if ({fp_l2_req_valid, fp_req_ack, fp_l2_flush_req, fp_in_flush_mode, fp_gnt_idx} !== 10'd0) begin
         errors++;
         $display("FAIL reset_outputs_fp: got %b expected all zero",
                  {fp_l2_req_valid, fp_req_ack, fp_l2_flush_req, fp_in_flush_mode, fp_gnt_idx});
      end
      @(posedge clk);
      #1;
      reset_n   = 1'b1;
      req_valid = 4'b0000;
      nxt();
      @(negedge clk);
      checks++;
      if (rr_l2_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_pending: got %b expected 0", rr_l2_req_valid);
      end
      nxt();
   endtask

   task automatic test_single();
      apply_reset();
      // c0: channel 1 requests
      req_valid = 4'b0010;
      req_addr[1*A +: A]       = 32'h0000_1000;
      req_opcode[1*O +: O]     = 4'h5;
      req_store_data[1*L +: L] = 128'hDEAD_BEEF;
      nxt();
      // c1: granted
      req_valid = 4'b0000;
      @(negedge clk);
      checks++;
      if (rr_l2_req_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", rr_l2_req_valid); end
      checks++;
      if (rr_l2_req_addr !== 32'h0000_1000) begin errors++; $display("FAIL single_addr: got %h expected 00001000", rr_l2_req_addr); end
      checks++;
      if ({rr_l2_req_opcode, rr_l2_req_store_data} !== {4'h5, 128'hDEAD_BEEF}) begin
         errors++; $display("FAIL single_op_data: got %h %h expected 5 deadbeef", rr_l2_req_opcode, rr_l2_req_store_data);
      end
      checks++;
      if (rr_gnt_idx !== 2'd1) begin errors++; $display("FAIL single_gnt: got %0d expected 1", rr_gnt_idx); end
      checks++;
      if (rr_req_ack !== 4'b0000) begin errors++; $display("FAIL single_early_ack: got %b expected 0000", rr_req_ack); end
      nxt();
      // c2: channel 1 re-requests during its own grant
      req_valid = 4'b0010;
      nxt();
      // c3: L2 accepts
      req_valid  = 4'b0000;
      l2_req_ack = 1'b1;
      @(negedge clk);
      checks++;
      if (rr_req_ack !== 4'b0010) begin errors++; $display("FAIL single_ack: got %b expected 0010", rr_req_ack); end
      nxt();
      // c4: request dropped after ack
      l2_req_ack = 1'b0;
      @(negedge clk);
      checks++;
      if (rr_l2_req_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop: got %b expected 0", rr_l2_req_valid); end
      nxt();
      nxt();
      // c6: response
      l2_rsp_valid     = 1'b1;
      l2_rsp_load_data = 128'hAB;
      @(negedge clk);
      checks++;
      if (rr_rsp_valid !== 4'b0010) begin errors++; $display("FAIL single_rsp: got %b expected 0010", rr_rsp_valid); end
      checks++;
      if (rr_rsp_load_data !== 128'hAB) begin errors++; $display("FAIL single_rsp_data: got %h expected ab", rr_rsp_load_data); end
      nxt();
      // c7: back in IDLE
      l2_rsp_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (rr_l2_req_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap: got %b expected 0", rr_l2_req_valid); end
      nxt();
      // c8: pending re-request granted; ack and response in the same cycle
      l2_req_ack   = 1'b1;
      l2_rsp_valid = 1'b1;
      @(negedge clk);
      checks++;
      if ({rr_l2_req_valid, rr_gnt_idx} !== {1'b1, 2'd1}) begin
         errors++; $display("FAIL b2b_regrant: got %b/%0d expected 1/1", rr_l2_req_valid, rr_gnt_idx);
      end
      checks++;
      if ({rr_req_ack, rr_rsp_valid} !== {4'b0010, 4'b0010}) begin
         errors++; $display("FAIL simul_ack_rsp: got %b %b expected 0010 0010", rr_req_ack, rr_rsp_valid);
      end
      nxt();
      // c9: idle; a stray response must not be routed
      l2_req_ack = 1'b0;
      @(negedge clk);
      checks++;
      if ({rr_l2_req_valid, rr_rsp_valid} !== 5'b0_0000) begin
         errors++; $display("FAIL simul_idle: got %b %b expected 0 0000", rr_l2_req_valid, rr_rsp_valid);
      end
      nxt();
      clear_strobes();
      @(negedge clk);
      checks++;
      if (rr_l2_req_valid !== 1'b0) begin errors++; $display("FAIL single_no_extra: got %b expected 0", rr_l2_req_valid); end
      nxt();
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      int got = 0;
      apply_reset();
      for (int i = 0; i < N; i++) req_addr[i*A +: A] = 32'h2000 + 32'(i * 16);
      for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
         req_valid = 4'b1111;
         if (rr_l2_req_valid === 1'b1) begin
            checks++;
            if (rr_gnt_idx !== exp_order[got]) begin
               errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", got, rr_gnt_idx, exp_order[got]);
            end
            checks++;
            if (rr_l2_req_addr !== 32'h2000 + 32'(exp_order[got]) * 32'd16) begin
               errors++; $display("FAIL rr_addr[%0d]: got %h expected %h", got, rr_l2_req_addr,
                                  32'h2000 + 32'(exp_order[got]) * 32'd16);
            end
            l2_req_ack   = 1'b1;
            l2_rsp_valid = 1'b1;
            got++;
         end else begin
            l2_req_ack   = 1'b0;
            l2_rsp_valid = 1'b0;
         end
         nxt();
      end
      checks++;
      if (got != 5) begin errors++; $display("FAIL rr_grant_count: got %0d expected 5", got); end
      clear_strobes();
      nxt();
   endtask

   task automatic test_fixed_priority();
      logic [1:0] exp_order [3] = '{2'd2, 2'd2, 2'd3};
      int got = 0;
      apply_reset();
      req_valid = 4'b1100;
      nxt();
      for (int cyc = 0; cyc < 30 && got < 3; cyc++) begin
         req_valid = 4'b0000;
         if (fp_l2_req_valid === 1'b1) begin
            checks++;
            if (fp_gnt_idx !== exp_order[got]) begin
               errors++; $display("FAIL fp_order[%0d]: got %0d expected %0d", got, fp_gnt_idx, exp_order[got]);
            end
            // channel 2 asks again while granted; it still beats waiting channel 3
            if (got == 0) req_valid = 4'b0100;
            l2_req_ack   = 1'b1;
            l2_rsp_valid = 1'b1;
            got++;
         end else begin
            l2_req_ack   = 1'b0;
            l2_rsp_valid = 1'b0;
         end
         nxt();
      end
      checks++;
      if (got != 3) begin errors++; $display("FAIL fp_grant_count: got %0d expected 3", got); end
      clear_strobes();
      nxt();
   endtask

   task automatic test_flush();
      logic e_bit;
      apply_reset();
      req_valid = 4'b0001;
      nxt();
      req_valid  = 4'b0000;
      l2_req_ack = 1'b1;
      nxt();
      // k = 0: channel 0 transaction is waiting for its response
      for (int k = 0; k <= 14; k++) begin
         clear_strobes();
         case (k)
            0:       l1_flush_req      = 4'b0011;
            2:       l1_flush_complete = 4'b0010;
            5:       l1_flush_complete = 4'b0001;
            7:       l2_rsp_valid      = 1'b1;
            9:       req_valid         = 4'b0010;
            11:      l2_flush_complete = 1'b1;
            default: ;
         endcase
         @(negedge clk);
         e_bit = (k == 8);
         checks++;
         if (rr_l2_flush_req !== e_bit) begin errors++; $display("FAIL flush_l2_req[k=%0d]: got %b expected %b", k, rr_l2_flush_req, e_bit); end
         e_bit = (k >= 1 && k <= 11);
         checks++;
         if (rr_in_flush_mode !== e_bit) begin errors++; $display("FAIL flush_mode[k=%0d]: got %b expected %b", k, rr_in_flush_mode, e_bit); end
         e_bit = (k == 12);
         checks++;
         if (rr_flush_done !== e_bit) begin errors++; $display("FAIL flush_done[k=%0d]: got %b expected %b", k, rr_flush_done, e_bit); end
         e_bit = (k >= 13);
         checks++;
         if (rr_l2_req_valid !== e_bit) begin errors++; $display("FAIL flush_hold_grant[k=%0d]: got %b expected %b", k, rr_l2_req_valid, e_bit); end
         if (k == 7) begin
            checks++;
            if (rr_rsp_valid !== 4'b0001) begin errors++; $display("FAIL flush_rsp: got %b expected 0001", rr_rsp_valid); end
         end
         if (k == 13) begin
            checks++;
            if (rr_gnt_idx !== 2'd1) begin errors++; $display("FAIL flush_post_gnt: got %0d expected 1", rr_gnt_idx); end
         end
         nxt();
      end
      clear_strobes();
   endtask

   task automatic test_reset_mid_grant();
      apply_reset();
      req_valid = 4'b0110;
      nxt();
      req_valid = 4'b0000;
      @(negedge clk);
      checks++;
      if ({rr_l2_req_valid, rr_gnt_idx} !== {1'b1, 2'd1}) begin
         errors++; $display("FAIL midrst_pre: got %b/%0d expected 1/1", rr_l2_req_valid, rr_gnt_idx);
      end
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      nxt();
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({rr_l2_req_valid, rr_req_ack, rr_rsp_valid, rr_l2_flush_req, rr_in_flush_mode,
           rr_flush_done, rr_gnt_idx} !== 14'd0) begin
         errors++;
         $display("FAIL midrst_outputs: got %b expected all zero", {rr_l2_req_valid, rr_req_ack,
                  rr_rsp_valid, rr_l2_flush_req, rr_in_flush_mode, rr_flush_done, rr_gnt_idx});
      end
      nxt();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         if (rr_l2_req_valid !== 1'b0) begin errors++; $display("FAIL midrst_pend_cleared[%0d]: got %b expected 0", c, rr_l2_req_valid); end
         nxt();
      end
      req_valid = 4'b0011;
      nxt();
      req_valid = 4'b0000;
      @(negedge clk);
      checks++;
      if ({rr_l2_req_valid, rr_gnt_idx} !== {1'b1, 2'd0}) begin
         errors++; $display("FAIL midrst_first_rr: got %b/%0d expected 1/0", rr_l2_req_valid, rr_gnt_idx);
      end
      nxt();
   endtask

   initial begin
      reset_n        = 1'b0;
      req_addr       = {N*A{1'b0}};
      req_store_data = {N*L{1'b0}};
      req_opcode     = {N*O{1'b0}};
      clear_strobes();
      #1;
      test_reset();
      test_single();
      test_round_robin();
      test_fixed_priority();
      test_flush();
      test_reset_mid_grant();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
